// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-master to one-bus SRAM-style request arbiter with in-order response routing
module sram_req_arbiter #(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch side
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // load/store side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared bus
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        resp_err
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic               lock_q, lock_d;
  logic               lock_own_q, lock_own_d;   // 1 = data side holds the lock
  logic [MAX_OUT-1:0] own_q, own_d;             // owner FIFO storage, 1 = data
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               resp_err_q, resp_err_d;

  logic gnt_vld;
  logic gnt_data;
  logic full;
  logic pop;
  logic accept;
  logic head_data;

  // Owner selection: a stalled owner keeps the bus, otherwise data side has priority.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_data = 1'b0;
    if (lock_q) begin
      gnt_vld  = 1'b1;
      gnt_data = lock_own_q;
    end else if (data_req) begin
      gnt_vld  = 1'b1;
      gnt_data = 1'b1;
    end else if (inst_req) begin
      gnt_vld  = 1'b1;
    end
  end

  assign full      = (count_q == CW'(MAX_OUT));
  assign pop       = bus_data_ok && (count_q != '0);
  assign head_data = own_q[rd_ptr_q];

  // A full FIFO only admits a new request when a response frees a slot in the same cycle.
  assign bus_req   = resetn && gnt_vld && (!full || bus_data_ok);
  assign accept    = bus_req && bus_addr_ok;

  // Request fields follow the granted owner combinationally.
  always_comb begin
    bus_wr    = inst_wr;
    bus_size  = inst_size;
    bus_wstrb = inst_wstrb;
    bus_addr  = inst_addr;
    bus_wdata = inst_wdata;
    if (gnt_data) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_wstrb = data_wstrb;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end
  end

  assign inst_addr_ok = accept && !gnt_data;
  assign data_addr_ok = accept && gnt_data;
  assign inst_data_ok = pop && !head_data;
  assign data_data_ok = pop && head_data;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;
  assign resp_err     = resp_err_q;

  // Next-state for lock, owner FIFO, occupancy and the sticky error flag.
  always_comb begin
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    own_d      = own_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    resp_err_d = resp_err_q;

    if (accept) begin
      lock_d = 1'b0;
    end else if (bus_req) begin
      lock_d     = 1'b1;
      lock_own_d = gnt_data;
    end

    if (accept) begin
      own_d[wr_ptr_q] = gnt_data;
      wr_ptr_d = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (bus_data_ok && (count_q == '0)) begin
      resp_err_d = 1'b1;
    end
  end

  // State registers; reset discards every outstanding ownership record.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q     <= 1'b0;
      lock_own_q <= 1'b0;
      own_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      own_q      <= own_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - scoreboard bench for sram_req_arbiter
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        resp_err;

  typedef struct {
    logic        data;
    logic [31:0] val;
  } exp_t;

  exp_t acc_q[$];
  exp_t resp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.MAX_OUT(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .resp_err(resp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 1'b0; data_req = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
  endtask

  task automatic push_acc(input logic d, input logic [31:0] a);
    exp_t e;
    e.data = d; e.val = a;
    acc_q.push_back(e);
  endtask

  task automatic push_resp(input logic d, input logic [31:0] v);
    exp_t e;
    e.data = d; e.val = v;
    resp_q.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT signals an accept or a response.
  always @(negedge clk) begin
    exp_t e;
    if (inst_addr_ok || data_addr_ok) begin
      if (acc_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_accept: inst_addr_ok=%0b data_addr_ok=%0b with none expected at %0t",
                 inst_addr_ok, data_addr_ok, $time);
      end else begin
        e = acc_q.pop_front();
        chk("accept_owner", {30'd0, inst_addr_ok, data_addr_ok}, e.data ? 32'd1 : 32'd2);
        chk("accept_addr", bus_addr, e.val);
      end
    end
    if (inst_data_ok || data_data_ok) begin
      if (resp_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_resp: inst_data_ok=%0b data_data_ok=%0b with none expected at %0t",
                 inst_data_ok, data_data_ok, $time);
      end else begin
        e = resp_q.pop_front();
        chk("resp_owner", {30'd0, inst_data_ok, data_data_ok}, e.data ? 32'd1 : 32'd2);
        chk("resp_rdata", e.data ? data_rdata : inst_rdata, e.val);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    idle();
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_addr = '0; inst_wdata = '0;
    data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF; data_addr = '0; data_wdata = 32'hDEAD_BEEF;
    bus_rdata = '0;

    // reset: requests high must not reach the bus
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("reset_bus_req", bus_req, 0);
    chk("reset_count", dut.count_q, 0);
    chk("reset_resp_err", resp_err, 0);
    tick();
    resetn = 1'b1; idle();
    tick();

    // both requests: data wins
    inst_req = 1'b1; inst_addr = 32'h1000;
    data_req = 1'b1; data_addr = 32'h2000; bus_addr_ok = 1'b1;
    push_acc(1'b1, 32'h2000);
    @(negedge clk);
    chk("prio_bus_req", bus_req, 1);
    tick(); idle();
    chk("prio_count", dut.count_q, 1);
    bus_data_ok = 1'b1; bus_rdata = 32'hA5A5_0001; push_resp(1'b1, 32'hA5A5_0001);
    tick(); idle();
    chk("drain_count", dut.count_q, 0);

    // lock: inst held while stalled even after data rises
    inst_req = 1'b1; inst_addr = 32'h1100; data_addr = 32'h2200;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) data_req = 1'b1;
      @(negedge clk);
      chk("lock_bus_req", bus_req, 1);
      chk("lock_bus_addr", bus_addr, 32'h1100);
      tick();
    end
    bus_addr_ok = 1'b1; push_acc(1'b0, 32'h1100);
    tick();
    inst_req = 1'b0; push_acc(1'b1, 32'h2200);
    tick(); idle();
    chk("two_out_count", dut.count_q, 2);

    // full: third request blocked, then admitted alongside a response
    data_req = 1'b1; data_addr = 32'h2300; data_wr = 1'b1; bus_addr_ok = 1'b1;
    @(negedge clk);
    chk("full_bus_req", bus_req, 0);
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
    push_resp(1'b0, 32'h1234_5678); push_acc(1'b1, 32'h2300);
    @(negedge clk);
    chk("full_inst_rdata", inst_rdata, 32'h1234_5678);
    chk("full_bus_wr", bus_wr, 1);
    tick(); idle(); data_wr = 1'b0;
    chk("full_count", dut.count_q, 2);
    bus_data_ok = 1'b1; bus_rdata = 32'hA5A5_0002; push_resp(1'b1, 32'hA5A5_0002);
    tick(); idle();
    chk("pop1_count", dut.count_q, 1);
    bus_data_ok = 1'b1; bus_rdata = 32'hA5A5_0003; push_resp(1'b1, 32'hA5A5_0003);
    tick(); idle();
    chk("pop2_count", dut.count_q, 0);

    // same-cycle push and pop at count 1
    inst_req = 1'b1; inst_addr = 32'h1400; bus_addr_ok = 1'b1; push_acc(1'b0, 32'h1400);
    tick(); idle();
    chk("pp_pre_count", dut.count_q, 1);
    data_req = 1'b1; data_addr = 32'h2400; bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1; bus_rdata = 32'hA5A5_0004;
    push_acc(1'b1, 32'h2400); push_resp(1'b0, 32'hA5A5_0004);
    tick(); idle();
    chk("pp_count", dut.count_q, 1);
    bus_data_ok = 1'b1; bus_rdata = 32'hA5A5_0005; push_resp(1'b1, 32'hA5A5_0005);
    tick(); idle();
    chk("pp_post_count", dut.count_q, 0);

    // orphan response: sticky error
    bus_data_ok = 1'b1; bus_rdata = 32'hA5A5_0006;
    tick(); idle();
    chk("orphan_resp_err", resp_err, 1);
    chk("orphan_count", dut.count_q, 0);
    tick();
    chk("orphan_err_held", resp_err, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("err_cleared", resp_err, 0);
    tick(); resetn = 1'b1;
    tick();

    // reset with two outstanding
    inst_req = 1'b1; inst_addr = 32'h1500; bus_addr_ok = 1'b1; push_acc(1'b0, 32'h1500);
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h2500; push_acc(1'b1, 32'h2500);
    tick();
    chk("pre_reset_count", dut.count_q, 2);
    inst_req = 1'b1; data_req = 1'b1;
    #2 resetn = 1'b0;
    #1;
    chk("async_count", dut.count_q, 0);
    chk("async_bus_req", bus_req, 0);
    tick();
    chk("hold_bus_req", bus_req, 0);
    idle(); resetn = 1'b1;
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'hA5A5_0007;
    tick(); idle();
    chk("post_reset_err", resp_err, 1);
    chk("post_reset_count", dut.count_q, 0);
    tick();

    chk("acc_queue_empty", acc_q.size(), 0);
    chk("resp_queue_empty", resp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter MAX_OUT, default 2, meaning maximum outstanding bus transactions (legal values 1..4).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 inst_req / inst_wr / inst_size / inst_wstrb / inst_addr / inst_wdata  in  1/1/2/4/32/32  fetch-side request.
REQ-005 inst_addr_ok, inst_data_ok  out  1 each  fetch-side accept / response; inst_rdata  out  32  fetch read data.
REQ-006 data_req / data_wr / data_size / data_wstrb / data_addr / data_wdata  in  1/1/2/4/32/32  load/store-side request.
REQ-007 data_addr_ok, data_data_ok  out  1 each  load/store accept / response; data_rdata  out  32  load read data.
REQ-008 bus_req / bus_wr / bus_size / bus_wstrb / bus_addr / bus_wdata  out  1/1/2/4/32/32  shared bus request.
REQ-009 bus_addr_ok, bus_data_ok  in  1 each  shared bus accept / response; bus_rdata  in  32  bus read data.
REQ-010 resp_err  out  1  sticky flag: bus_data_ok arrived with no outstanding transaction.

Function
REQ-011 A request is accepted in the cycle bus_req & bus_addr_ok is high; exactly one of inst_addr_ok or data_addr_ok SHALL pulse high that cycle, matching the granted owner.
REQ-012 Grant when unlocked: data side wins if data_req; otherwise inst side if inst_req.
REQ-013 Lock: if bus_req is high and bus_addr_ok is low, the granted owner SHALL be registered and held until its acceptance, even if the other side raises req.
REQ-014 Lock clears in the accept cycle; the next cycle re-arbitrates per REQ-012.
REQ-015 All bus_* request fields SHALL be driven combinationally from the granted owner's inputs; with no grant, bus_req=0 and the other fields are don't-care.
REQ-016 Owner FIFO: depth MAX_OUT, one bit per entry (1=data, 0=inst), pushed on each accept, popped on each bus_data_ok; occupancy counter width ceil(log2(MAX_OUT+1)).
REQ-017 FIFO full (count==MAX_OUT): bus_req SHALL be 0 and no addr_ok issued, unless bus_data_ok is high that same cycle (pop frees a slot; same-cycle accept allowed).
REQ-018 Same-cycle push and pop: count unchanged; the popped entry is the old head; the pushed entry goes to the tail.
REQ-019 Responses are in order: bus_data_ok is routed to the FIFO head owner; data_data_ok or inst_data_ok SHALL pulse for one cycle, combinationally in the bus_data_ok cycle (zero added latency).
REQ-020 inst_rdata and data_rdata SHALL both equal bus_rdata (pass-through); validity is qualified only by the matching data_ok.
REQ-021 bus_data_ok with FIFO empty: no data_ok to either side, count stays 0, resp_err set to 1 and held until reset.
REQ-022 Requester cancellation (flush) is not visible to the arbiter; every accepted transaction SHALL receive exactly one routed data_ok.
REQ-023 Read/write symmetry: writes also occupy a FIFO slot and receive data_ok.
REQ-024 Max throughput: one accept per cycle and one response per cycle concurrently.

Reset
REQ-025 While resetn=0 (asynchronous): lock cleared, FIFO count 0, FIFO pointers 0, resp_err 0.
REQ-026 Outputs during reset: bus_req 0, all addr_ok/data_ok 0.
REQ-027 Reset asserted mid-transaction discards all outstanding ownership; post-reset responses with an empty FIFO follow REQ-021.

Verification
REQ-028 Both req high, bus_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, bus_addr = data_addr, count 0->1.
REQ-029 inst_req alone with bus_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> bus still shows inst_addr until accept, then data granted the next cycle.
REQ-030 MAX_OUT=2, accept inst then data, no responses -> third request gets no addr_ok, bus_req=0; then bus_data_ok with rdata=0x12345678 -> inst_data_ok=1, inst_rdata=0x12345678, and a pending request is accepted the same cycle.
REQ-031 Same-cycle accept (data) and response (inst head) at count=1 -> inst_data_ok=1, count stays 1, next response goes to data.
REQ-032 bus_data_ok with count=0 -> no data_ok, resp_err=1 and held; resetn pulse -> resp_err=0.
REQ-033 resetn dropped with 2 outstanding -> count 0 immediately (asynchronous), bus_req 0 until resetn rises.
